// File: rtl/muldiv_if.sv
// Execute-stage handshake between the pipeline and the RV32M multiply/divide sequencer.
interface muldiv_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic            mul_stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, flush, funct3, op1, op2,
      input  mul_stall, done, result
   );

   modport slave (
      input  start, flush, funct3, op1, op2,
      output mul_stall, done, result
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative RV32M sequencer: 32-step shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up and short-circuited x/0 and overflow cases.
module muldiv_ctrl #(
   parameter int XLEN = 32
) (
   input  logic     clk,
   input  logic     rst,
   muldiv_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [2:0]        f3_q, f3_d;
   logic              neg1_q, neg1_d, neg2_q, neg2_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              sgn1_s, sgn2_s, neg1_s, neg2_s, div0_s, ovf_s;
   logic [XLEN-1:0]   abs1_s, abs2_s, special_s;
   logic [XLEN:0]     sum_s, shl_s;
   logic [XLEN-1:0]   diff_s, quo_s, rem_s, fix_res_s;
   logic [2*XLEN-1:0] prod_s;

   // Operand decode: signedness per funct3, magnitudes and short-circuit results.
   always_comb begin
      sgn1_s    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      sgn2_s    = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      neg1_s    = sgn1_s & bus.op1[XLEN-1];
      neg2_s    = sgn2_s & bus.op2[XLEN-1];
      abs1_s    = neg1_s ? (32'd0 - bus.op1) : bus.op1;
      abs2_s    = neg2_s ? (32'd0 - bus.op2) : bus.op2;
      div0_s    = bus.funct3[2] && (bus.op2 == 32'd0);
      ovf_s     = bus.funct3[2] && !bus.funct3[0] &&
                  (bus.op1 == 32'h8000_0000) && (bus.op2 == 32'hFFFF_FFFF);
      if (div0_s) begin
         special_s = bus.funct3[1] ? bus.op1 : 32'hFFFF_FFFF;
      end else begin
         special_s = bus.funct3[1] ? 32'd0 : 32'h8000_0000;
      end
   end

   // One iteration of each datapath plus the sign-corrected result selection.
   always_comb begin
      sum_s  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
      shl_s  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      diff_s = shl_s[XLEN-1:0] - b_q;
      prod_s = (neg1_q ^ neg2_q) ? (64'd0 - acc_q) : acc_q;
      quo_s  = (neg1_q ^ neg2_q) ? (32'd0 - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
      rem_s  = neg1_q ? (32'd0 - acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
      case (f3_q)
         3'b000:                  fix_res_s = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011:  fix_res_s = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:          fix_res_s = quo_s;
         3'b110, 3'b111:          fix_res_s = rem_s;
         default:                 fix_res_s = 32'd0;
      endcase
   end

   // Next-state logic; flush overrides every transition and leaves result untouched.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      f3_d     = f3_q;
      neg1_d   = neg1_q;
      neg2_d   = neg2_q;
      b_d      = b_q;
      acc_d    = acc_q;
      result_d = result_q;
      if (bus.flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  f3_d   = bus.funct3;
                  neg1_d = neg1_s;
                  neg2_d = neg2_s;
                  b_d    = abs2_s;
                  acc_d  = {32'd0, abs1_s};
                  if (div0_s || ovf_s) begin
                     result_d = special_s;
                     state_d  = S_DONE;
                  end else begin
                     cnt_d   = 5'd31;
                     state_d = S_CALC;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CALC: begin
               if (!f3_q[2]) begin
                  acc_d = {sum_s, acc_q[XLEN-1:1]};
               end else if (shl_s >= {1'b0, b_q}) begin
                  acc_d = {diff_s, acc_q[XLEN-2:0], 1'b1};
               end else begin
                  acc_d = {shl_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
               end
               if (cnt_q == 5'd0) begin
                  state_d = S_FIX;
               end else begin
                  cnt_d = cnt_q - 5'd1;
               end
            end
            S_FIX: begin
               result_d = fix_res_s;
               state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         f3_q     <= 3'd0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         b_q      <= 32'd0;
         acc_q    <= 64'd0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         f3_q     <= f3_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   // The stall must rise in the same cycle as start, so it is decoded combinationally.
   assign bus.mul_stall = rst & (((state_q == S_IDLE) & bus.start & ~bus.flush) |
                                 (state_q == S_CALC) | (state_q == S_FIX));
   assign bus.done      = (state_q == S_DONE);
   assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: latency, results, special cases, flush and reset abort.
module tb_muldiv_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   pass_cnt = 0;
   int   chk_cnt  = 0;

   muldiv_if #(.XLEN(32)) bus ();
   muldiv_ctrl #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Issue one op at the next negedge (cycle T) and observe until done or a 60-cycle budget.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int lat, output int stalls,
                         output logic stall_done, output logic [31:0] res);
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = f3; bus.op1 = a; bus.op2 = b;
      #1;
      stalls = int'(bus.mul_stall); lat = 0; res = 32'hxxxx_xxxx; stall_done = 1'bx;
      for (int c = 1; c <= 60 && lat == 0; c++) begin
         @(negedge clk);
         if (!hold) begin
            bus.start = 1'b0; bus.op1 = $urandom; bus.op2 = $urandom;
         end
         #1;
         if (bus.done) begin
            lat = c; res = bus.result; stall_done = bus.mul_stall;
         end else begin
            stalls += int'(bus.mul_stall);
         end
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = 3'b000; bus.op1 = 32'd3; bus.op2 = 32'd4;
      #2;
      chk_cnt++; if (bus.mul_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", bus.mul_stall); else pass_cnt++;
      chk_cnt++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else pass_cnt++;
      chk_cnt++; if (bus.result !== 32'd0) $display("FAIL reset_result got %h want 0", bus.result); else pass_cnt++;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_mul();
      int lat, st; logic sd; logic [31:0] r;
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'hFFFF_FFEB) $display("FAIL mul_res got %h want ffffffeb", r); else pass_cnt++;
      chk_cnt++; if (lat !== 34) $display("FAIL mul_latency got %0d want 34", lat); else pass_cnt++;
      chk_cnt++; if (st !== 34) $display("FAIL mul_stall_cycles got %0d want 34", st); else pass_cnt++;
      chk_cnt++; if (sd !== 1'b0) $display("FAIL mul_stall_at_done got %b want 0", sd); else pass_cnt++;
      run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'hFFFF_FFFE) $display("FAIL mulhu_res got %h want fffffffe", r); else pass_cnt++;
      run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'h0000_0000) $display("FAIL mulh_res got %h want 00000000", r); else pass_cnt++;
      run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL mulhsu_res got %h want ffffffff", r); else pass_cnt++;
      chk_cnt++; if (lat !== 34) $display("FAIL mulhsu_latency got %0d want 34", lat); else pass_cnt++;
   endtask

   task automatic test_div();
      int lat, st; logic sd; logic [31:0] r;
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'hFFFF_FFFD) $display("FAIL div_res got %h want fffffffd", r); else pass_cnt++;
      chk_cnt++; if (lat !== 34) $display("FAIL div_latency got %0d want 34", lat); else pass_cnt++;
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL rem_res got %h want ffffffff", r); else pass_cnt++;
      run_op(3'b101, 32'd100, 32'd7, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'd14) $display("FAIL divu_res got %h want 0000000e", r); else pass_cnt++;
      run_op(3'b111, 32'd100, 32'd7, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'd2) $display("FAIL remu_res got %h want 00000002", r); else pass_cnt++;
   endtask

   task automatic test_flush();
      int lat, st, dn; logic sd; logic [31:0] r;
      dn = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b100; bus.op1 = 32'd1000; bus.op2 = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk); bus.start = 1'b0;
         if (c == 10) bus.flush = 1'b1;
         #1; dn += int'(bus.done);
      end
      @(negedge clk); bus.flush = 1'b0;
      #1; dn += int'(bus.done);
      chk_cnt++; if (bus.mul_stall !== 1'b0) $display("FAIL flush_idle_stall got %b want 0", bus.mul_stall); else pass_cnt++;
      chk_cnt++; if (dn !== 0) $display("FAIL flush_done_count got %0d want 0", dn); else pass_cnt++;
      chk_cnt++; if (bus.result !== 32'd2) $display("FAIL flush_result_kept got %h want 00000002", bus.result); else pass_cnt++;
      run_op(3'b000, 32'd3, 32'd4, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'd12) $display("FAIL flush_next_mul got %h want 0000000c", r); else pass_cnt++;
      chk_cnt++; if (lat !== 34) $display("FAIL flush_next_latency got %0d want 34", lat); else pass_cnt++;
   endtask

   task automatic test_special();
      int lat, st; logic sd; logic [31:0] r;
      run_op(3'b101, 32'd5, 32'd0, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'hFFFF_FFFF) $display("FAIL divu0_res got %h want ffffffff", r); else pass_cnt++;
      chk_cnt++; if (lat !== 1) $display("FAIL divu0_latency got %0d want 1", lat); else pass_cnt++;
      chk_cnt++; if (st !== 1) $display("FAIL divu0_stall_cycles got %0d want 1", st); else pass_cnt++;
      run_op(3'b110, 32'd5, 32'd0, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'd5) $display("FAIL rem0_res got %h want 00000005", r); else pass_cnt++;
      chk_cnt++; if (lat !== 1) $display("FAIL rem0_latency got %0d want 1", lat); else pass_cnt++;
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'h8000_0000) $display("FAIL div_ovf_res got %h want 80000000", r); else pass_cnt++;
      chk_cnt++; if (lat !== 1) $display("FAIL div_ovf_latency got %0d want 1", lat); else pass_cnt++;
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'd0) $display("FAIL rem_ovf_res got %h want 00000000", r); else pass_cnt++;
      chk_cnt++; if (lat !== 1) $display("FAIL rem_ovf_latency got %0d want 1", lat); else pass_cnt++;
   endtask

   task automatic test_flush_start();
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000; bus.op1 = 32'd9; bus.op2 = 32'd9;
      #1;
      chk_cnt++; if (bus.mul_stall !== 1'b0) $display("FAIL flush_start_stall got %b want 0", bus.mul_stall); else pass_cnt++;
      @(negedge clk); bus.start = 1'b0; bus.flush = 1'b0;
      #1;
      chk_cnt++; if (bus.mul_stall !== 1'b0) $display("FAIL flush_start_no_op got %b want 0", bus.mul_stall); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat, st, dn; logic sd; logic [31:0] r;
      dn = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b000; bus.op1 = 32'h0001_2345; bus.op2 = 32'h0000_0777;
      for (int c = 1; c <= 19; c++) begin
         @(negedge clk); bus.start = 1'b0; #1; dn += int'(bus.done);
      end
      @(negedge clk); rst = 1'b0;
      #1;
      chk_cnt++; if (bus.mul_stall !== 1'b0) $display("FAIL rst_mid_stall got %b want 0", bus.mul_stall); else pass_cnt++;
      chk_cnt++; if (bus.result !== 32'd0) $display("FAIL rst_mid_result got %h want 00000000", bus.result); else pass_cnt++;
      chk_cnt++; if ((dn + int'(bus.done)) !== 0) $display("FAIL rst_mid_done got %0d want 0", dn + int'(bus.done)); else pass_cnt++;
      @(negedge clk); rst = 1'b1;
      run_op(3'b000, 32'd6, 32'd7, 1'b0, lat, st, sd, r);
      chk_cnt++; if (r !== 32'd42) $display("FAIL rst_mid_fresh got %h want 0000002a", r); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int lat, st, dn; logic sd; logic [31:0] r;
      dn = 0;
      run_op(3'b000, 32'd5, 32'd6, 1'b1, lat, st, sd, r);
      chk_cnt++; if (r !== 32'd30) $display("FAIL b2b_mul_res got %h want 0000001e", r); else pass_cnt++;
      chk_cnt++; if (lat !== 34) $display("FAIL b2b_mul_latency got %0d want 34", lat); else pass_cnt++;
      run_op(3'b100, 32'd50, 32'hFFFF_FFFB, 1'b1, lat, st, sd, r);
      chk_cnt++; if (r !== 32'hFFFF_FFF6) $display("FAIL b2b_div_res got %h want fffffff6", r); else pass_cnt++;
      chk_cnt++; if (lat !== 34) $display("FAIL b2b_div_latency got %0d want 34", lat); else pass_cnt++;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk); bus.start = 1'b0; #1; dn += int'(bus.done);
      end
      chk_cnt++; if (dn !== 0) $display("FAIL b2b_extra_done got %0d want 0", dn); else pass_cnt++;
   endtask

   initial begin
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'b000; bus.op1 = 32'd0; bus.op2 = 32'd0;
      test_reset();
      test_mul();
      test_div();
      test_flush();
      test_special();
      test_flush_start();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
